// File: rtl/pulse_event_scheduler_if.sv
// Event/handshake bundle between the scheduler and its neighbours.
// The scheduler owns the slave side; the producer and synchronizer model own the master side.
interface pulse_event_scheduler_if;
   logic [2:0] ev_in;
   logic       sync_busy;
   logic [2:0] sig_out;
   logic [2:0] pending;
   logic [2:0] overflow;
   logic       timeout;

   modport master (
      output ev_in,
      output sync_busy,
      input  sig_out,
      input  pending,
      input  overflow,
      input  timeout
   );

   modport slave (
      input  ev_in,
      input  sync_busy,
      output sig_out,
      output pending,
      output overflow,
      output timeout
   );
endinterface

// File: rtl/pulse_event_scheduler.sv
// Source-side event scheduler for the 3-bit pulse synchronizer.
// Counts pending events per channel and issues only while the crossing is idle.
module pulse_event_scheduler #(
   parameter int CNT_W  = 2,
   parameter int ACK_TO = 4,
   parameter int GAP    = 2
) (
   input logic clk,
   input logic rst,
   pulse_event_scheduler_if.slave bus
);

   localparam int AW = $clog2(ACK_TO + 1);
   localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
   localparam logic [CNT_W-1:0] MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      WAIT_IDLE,
      GUARD
   } state_t;

   state_t            state;
   logic [AW-1:0]     ack_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [CNT_W-1:0]  cnt [3];
   logic [CNT_W-1:0]  cnt_nxt [3];
   logic [2:0]        nz;
   logic [2:0]        iss;
   logic [2:0]        drop;
   logic              issue;
   logic [2:0]        issue_mask;
   logic [2:0]        pend;
   logic [2:0]        ovf;
   logic              tmo;

   // Issue decision: only from IDLE, with the crossing idle and work queued.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         nz[i] = (cnt[i] != '0);
      end
      issue = (state == IDLE) && (|nz) && !bus.sync_busy;
      iss   = issue ? nz : 3'b000;
   end

   // Per-channel counter update; an event at MAX is dropped unless it is
   // offset by an issue in the same cycle.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_nxt[i] = cnt[i];
         drop[i]    = 1'b0;
         if (bus.ev_in[i] && !iss[i]) begin
            if (cnt[i] == MAX) begin
               drop[i] = 1'b1;
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end else if (!bus.ev_in[i] && iss[i]) begin
            cnt_nxt[i] = cnt[i] - CNT_W'(1);
         end
      end
   end

   // Counters, handshake FSM and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ack_cnt    <= '0;
         gap_cnt    <= '0;
         issue_mask <= 3'b000;
         pend       <= 3'b000;
         ovf        <= 3'b000;
         tmo        <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            cnt[i]  <= cnt_nxt[i];
            pend[i] <= (cnt_nxt[i] != '0);
         end
         ovf        <= drop;
         issue_mask <= iss;
         tmo        <= 1'b0;
         unique case (state)
            IDLE: begin
               if (issue) begin
                  state   <= WAIT_ACK;
                  ack_cnt <= '0;
               end
            end
            WAIT_ACK: begin
               if (bus.sync_busy) begin
                  state <= WAIT_IDLE;
               end else if (ack_cnt == AW'(ACK_TO)) begin
                  tmo <= 1'b1;
                  if (GAP == 0) begin
                     state <= IDLE;
                  end else begin
                     state   <= GUARD;
                     gap_cnt <= GW'(GAP);
                  end
               end else begin
                  ack_cnt <= ack_cnt + AW'(1);
               end
            end
            WAIT_IDLE: begin
               if (!bus.sync_busy) begin
                  if (GAP == 0) begin
                     state <= IDLE;
                  end else begin
                     state   <= GUARD;
                     gap_cnt <= GW'(GAP);
                  end
               end
            end
            GUARD: begin
               if (gap_cnt <= GW'(1)) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sig_out  = issue_mask;
   assign bus.pending  = pend;
   assign bus.overflow = ovf;
   assign bus.timeout  = tmo;

endmodule

// File: tb/tb_pulse_event_scheduler.sv
// Directed bench for pulse_event_scheduler (CNT_W=2, ACK_TO=4, GAP=2).
// Cycle 0 is the first cycle after the reset edge.
module tb_pulse_event_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   pulse_event_scheduler_if bus ();

   pulse_event_scheduler #(
      .CNT_W  (2),
      .ACK_TO (4),
      .GAP    (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string t, input int c,
                             input logic [2:0] s, input logic [2:0] p,
                             input logic [2:0] o, input logic to);
      check($sformatf("%s.sig c%0d", t, c), 32'(bus.sig_out), 32'(s));
      check($sformatf("%s.pend c%0d", t, c), 32'(bus.pending), 32'(p));
      check($sformatf("%s.ovf c%0d", t, c), 32'(bus.overflow), 32'(o));
      check($sformatf("%s.to c%0d", t, c), 32'(bus.timeout), 32'(to));
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.ev_in     = 3'b000;
      bus.sync_busy = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.ev_in     = 3'b000;
      bus.sync_busy = 1'b0;

      // single event
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         bus.ev_in     = (c == 0) ? 3'b001 : 3'b000;
         bus.sync_busy = 1'b0;
         check_outs("single", c,
                    (c == 2) ? 3'b001 : 3'b000,
                    (c == 1) ? 3'b001 : 3'b000,
                    3'b000, 1'b0);
         tick();
      end

      // simultaneous channels
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         bus.ev_in     = (c == 0) ? 3'b101 : 3'b000;
         bus.sync_busy = 1'b0;
         check_outs("simul", c,
                    (c == 2) ? 3'b101 : 3'b000,
                    (c == 1) ? 3'b101 : 3'b000,
                    3'b000, 1'b0);
         tick();
      end

      // burst with overflow, then drain via timeouts
      do_reset();
      for (int c = 0; c <= 50; c++) begin
         bus.ev_in     = (c <= 4) ? 3'b010 : 3'b000;
         bus.sync_busy = (c >= 3 && c <= 19);
         check_outs("burst", c,
                    (c == 2 || c == 24 || c == 32 || c == 40)
                       ? 3'b010 : 3'b000,
                    (c >= 1 && c <= 39) ? 3'b010 : 3'b000,
                    (c == 5) ? 3'b010 : 3'b000,
                    (c == 29 || c == 37 || c == 45));
         tick();
      end

      // timeout and earliest re-issue
      do_reset();
      for (int c = 0; c <= 16; c++) begin
         bus.ev_in     = (c == 0 || c == 4) ? 3'b010 : 3'b000;
         bus.sync_busy = 1'b0;
         check_outs("tmo", c,
                    (c == 2 || c == 10) ? 3'b010 : 3'b000,
                    (c == 1 || (c >= 5 && c <= 9)) ? 3'b010 : 3'b000,
                    3'b000,
                    (c == 7 || c == 15));
         tick();
      end

      // busy hold
      do_reset();
      for (int c = 0; c <= 13; c++) begin
         bus.ev_in     = (c == 0) ? 3'b100 : 3'b000;
         bus.sync_busy = (c <= 9);
         check_outs("hold", c,
                    (c == 11) ? 3'b100 : 3'b000,
                    (c >= 1 && c <= 10) ? 3'b100 : 3'b000,
                    3'b000, 1'b0);
         tick();
      end

      // reset mid-operation while two events are still queued
      do_reset();
      for (int c = 0; c <= 20; c++) begin
         rst           = (c == 3);
         bus.ev_in     = (c <= 2) ? 3'b001 : 3'b000;
         bus.sync_busy = (c == 2 || c == 3);
         check_outs("rstmid", c,
                    (c == 2) ? 3'b001 : 3'b000,
                    (c >= 1 && c <= 3) ? 3'b001 : 3'b000,
                    3'b000, 1'b0);
         tick();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
